// File: rtl/matrix_pkg.sv
// Shared types and constants for the 5x7 LED matrix scan controller.
package matrix_pkg;

    localparam int         N_ROWS  = 5;
    localparam int         N_COLS  = 7;
    localparam int         MSG_W   = 16;
    localparam logic [6:0] COL_OFF = 7'h7F;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Active-low one-hot column drive for column index col.
    function automatic logic [6:0] col_drive(input logic [2:0] col);
        col_drive = COL_OFF & ~(7'b0000001 << col);
    endfunction

endpackage

// File: rtl/matrix_tick_gen.sv
// Slot prescaler and column counter for the matrix scan.
// slot_start is high during the last cycle of a slot: the new slot
// (prescaler 0, next column) begins at the following clock edge.
// frame_tick is a registered pulse in the cycle col has just wrapped 6->0.
module matrix_tick_gen
    import matrix_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    localparam int PW      = $clog2(SCAN_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [PW-1:0] prescaler,
    output logic          slot_start,
    output logic [2:0]    col,
    output logic          frame_tick
);

    localparam logic [PW-1:0] P_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [2:0]    COL_LAST = 3'(N_COLS - 1);

    assign slot_start = (prescaler == P_LAST);

    // Advance the prescaler; on wrap step the column and flag the frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler  <= '0;
            col        <= 3'd0;
            frame_tick <= 1'b0;
        end else if (slot_start) begin
            prescaler <= '0;
            if (col == COL_LAST) begin
                col        <= 3'd0;
                frame_tick <= 1'b1;
            end else begin
                col        <= col + 3'd1;
                frame_tick <= 1'b0;
            end
        end else begin
            prescaler  <= prescaler + PW'(1);
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/matrix_scan_controller.sv
// Column-multiplexed scan of a 5x7 LED matrix from a 16-bit-wide message,
// with static / scroll-left / scroll-right / blink modes picked by ch1:ch0.
// Optional half-brightness input 'dim' is compiled in with SCAN_DIM_EN.
module matrix_scan_controller
    import matrix_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_CYC     = 64,
    parameter int SCROLL_FRAMES = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch1,
    input  logic        ch0,
`ifdef SCAN_DIM_EN
    input  logic        dim,
`endif
    input  logic [79:0] msg_rows,
    output logic [6:0]  acender_coluna,
    output logic [4:0]  saida_linha,
    output logic        frame_tick,
    output logic [3:0]  offset
);

    localparam int            PW        = $clog2(SCAN_DIV);
    localparam int            CW        = $clog2(SCROLL_FRAMES + 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCROLL_FRAMES - 1);
`ifdef SCAN_DIM_EN
    localparam logic [PW-1:0] DIM_END   = PW'(BLANK_CYC + (SCAN_DIV - BLANK_CYC) / 2);
`endif

    logic [PW-1:0] prescaler;
    logic [PW-1:0] p_next;
    logic          slot_start;
    logic [2:0]    col;
    logic          blank_next;
    state_t        state;
    mode_t         mode;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [CW-1:0] frame_cnt;
    logic          blink_on;
    logic          step;
    logic [3:0]    msg_idx;
    logic [4:0]    row_bits;
    logic          visible;

    matrix_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .prescaler  (prescaler),
        .slot_start (slot_start),
        .col        (col),
        .frame_tick (frame_tick)
    );

    // Prescaler value that the next cycle will carry.
    assign p_next = slot_start ? '0 : prescaler + PW'(1);

`ifdef SCAN_DIM_EN
    logic dim_r;
    logic dim_next;

    assign dim_next = slot_start ? dim : dim_r;

    // Hold the dim request for the whole slot, sampled as the slot begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            dim_r <= 1'b0;
        end else if (slot_start) begin
            dim_r <= dim;
        end else begin
            dim_r <= dim_r;
        end
    end
`endif

    // Blank/drive decision for the prescaler value of the next cycle.
    always_comb begin
        blank_next = (p_next < BLANK_END);
`ifdef SCAN_DIM_EN
        if (dim_next && (p_next >= DIM_END)) begin
            blank_next = 1'b1;
        end else begin
            blank_next = blank_next;
        end
`endif
    end

    // Message bit index shown in the current column: window offset plus column, mod 16.
    assign msg_idx = offset + {1'b0, col};

    // Pick one message bit per row for the current column.
    always_comb begin
        row_bits = 5'b00000;
        for (int r = 0; r < N_ROWS; r++) begin
            row_bits[r] = msg_rows[r*MSG_W + int'(msg_idx)];
        end
    end

    // Blink OFF phase makes DRIVE look exactly like BLANK.
    assign visible = (state == ST_DRIVE) && !((mode == MODE_BLINK) && !blink_on);

    // Scan FSM together with the registered pin drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_BLANK;
            acender_coluna <= COL_OFF;
            saida_linha    <= 5'b00000;
        end else begin
            case (state)
                ST_BLANK: state <= blank_next ? ST_BLANK : ST_DRIVE;
                ST_DRIVE: state <= blank_next ? ST_BLANK : ST_DRIVE;
                default:  state <= ST_BLANK;
            endcase
            if (visible) begin
                acender_coluna <= col_drive(col);
                saida_linha    <= row_bits;
            end else begin
                acender_coluna <= COL_OFF;
                saida_linha    <= 5'b00000;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous mode switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {ch1, ch0};
            sync2 <= sync1;
        end
    end

    assign step = (frame_cnt == CNT_LAST);

    // Frame-boundary bookkeeping: scroll step / blink toggle under the old mode,
    // then a pending mode change restarts the counter with blink forced ON.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= MODE_STATIC;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            offset    <= 4'd0;
        end else if (frame_tick) begin
            if (step) begin
                case (mode)
                    MODE_LEFT:  offset <= offset + 4'd1;
                    MODE_RIGHT: offset <= offset - 4'd1;
                    default:    offset <= offset;
                endcase
            end else begin
                offset <= offset;
            end
            if (sync2 != mode) begin
                mode      <= mode_t'(sync2);
                frame_cnt <= '0;
                blink_on  <= 1'b1;
            end else begin
                mode      <= mode;
                frame_cnt <= step ? '0 : frame_cnt + CW'(1);
                blink_on  <= (step && (mode == MODE_BLINK)) ? ~blink_on : blink_on;
            end
        end else begin
            mode      <= mode;
            frame_cnt <= frame_cnt;
            blink_on  <= blink_on;
            offset    <= offset;
        end
    end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Self-checking bench for matrix_scan_controller (SCAN_DIV=4, BLANK_CYC=1, SCROLL_FRAMES=2).
// The reference model derives prescaler and column from a plain cycle count since reset.
module tb_matrix_scan_controller;

    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int SF    = 2;
    localparam int FRAME = SD * 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ch1 = 1'b0;
    logic        ch0 = 1'b0;
    logic [79:0] msg_rows = '0;
    logic [6:0]  acender_coluna;
    logic [4:0]  saida_linha;
    logic        frame_tick;
    logic [3:0]  offset;

    int checks = 0;
    int errors = 0;

    // model state: m_n = cycles since the reset edge for the current cycle
    int       m_n, m_mode, m_off, m_cnt, m_s1, m_s2;
    bit       m_on;
    logic [6:0] e_col;
    logic [4:0] e_row;
    logic       e_ft;
    logic [3:0] e_off;

    always #5 clk = ~clk;

    matrix_scan_controller #(
        .SCAN_DIV      (SD),
        .BLANK_CYC     (BC),
        .SCROLL_FRAMES (SF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch1            (ch1),
        .ch0            (ch0),
        .msg_rows       (msg_rows),
        .acender_coluna (acender_coluna),
        .saida_linha    (saida_linha),
        .frame_tick     (frame_tick),
        .offset         (offset)
    );

    // Advance one clock: predict what the pins show after this edge, then sample at +1.
    task automatic tick();
        int p, c;
        bit vis, ft_now, stp;
        logic [6:0] nc;
        logic [4:0] nr;
        nc = 7'h7F;
        nr = 5'd0;
        if (rst) begin
            m_n = 0; m_mode = 0; m_off = 0; m_cnt = 0; m_on = 1'b1; m_s1 = 0; m_s2 = 0;
            e_ft = 1'b0;
        end else begin
            p = m_n % SD;
            c = (m_n / SD) % 7;
            vis = (p >= BC) && !(m_mode == 3 && !m_on);
            if (vis) begin
                nc[c] = 1'b0;
                for (int r = 0; r < 5; r++) nr[r] = msg_rows[r*16 + ((m_off + c) % 16)];
            end
            ft_now = (m_n > 0) && (m_n % FRAME == 0);
            if (ft_now) begin
                stp = (m_cnt == SF - 1);
                if (stp && m_mode == 1) m_off = (m_off + 1) % 16;
                if (stp && m_mode == 2) m_off = (m_off + 15) % 16;
                if (m_s2 != m_mode) begin
                    m_mode = m_s2; m_cnt = 0; m_on = 1'b1;
                end else begin
                    m_cnt = stp ? 0 : m_cnt + 1;
                    if (stp && m_mode == 3) m_on = !m_on;
                end
            end
            m_s2 = m_s1;
            m_s1 = int'({ch1, ch0});
            m_n++;
            e_ft = (m_n % FRAME == 0);
        end
        @(posedge clk);
        e_col = nc;
        e_row = nr;
        e_off = 4'(m_off);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] ch);
        {ch1, ch0} = ch;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({acender_coluna, saida_linha, frame_tick, offset} !== {7'h7F, 5'h00, 1'b0, 4'h0}) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got %b_%b_%b_%h expected 1111111_00000_0_0", i, acender_coluna, saida_linha, frame_tick, offset);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({acender_coluna, saida_linha, frame_tick, offset} !== {7'h7F, 5'h00, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_release got %b_%b_%b_%h expected 1111111_00000_0_0", acender_coluna, saida_linha, frame_tick, offset);
        end
    endtask

    task automatic test_static();
        int lit0 = 0;
        int stray = 0;
        msg_rows = '0;
        msg_rows[15:0] = 16'h0001;
        do_reset(2'b00);
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick();
            checks++;
            if ({acender_coluna, saida_linha, frame_tick, offset} !== {e_col, e_row, e_ft, e_off}) begin
                errors++;
                $display("FAIL static_out k=%0d got %b_%b_%b_%h expected %b_%b_%b_%h", k, acender_coluna, saida_linha, frame_tick, offset, e_col, e_row, e_ft, e_off);
            end
            if (acender_coluna == 7'b1111110 && saida_linha == 5'b00001) lit0++;
            if (saida_linha != 5'b00000 && acender_coluna != 7'b1111110) stray++;
        end
        checks++;
        if (lit0 != 3 * (SD - BC)) begin
            errors++;
            $display("FAIL static_col0_cycles got %0d expected %0d", lit0, 3 * (SD - BC));
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL static_other_cols got %0d expected 0", stray);
        end
    endtask

    task automatic test_scroll_left();
        logic [15:0] seen = 16'h0000;
        int c6 = 0;
        int c6_off1 = 0;
        msg_rows = '0;
        msg_rows[15:0] = 16'h0080;
        do_reset(2'b01);
        for (int k = 0; k < 36 * FRAME; k++) begin
            tick();
            checks++;
            if ({acender_coluna, saida_linha, frame_tick, offset} !== {e_col, e_row, e_ft, e_off}) begin
                errors++;
                $display("FAIL left_out k=%0d got %b_%b_%b_%h expected %b_%b_%b_%h", k, acender_coluna, saida_linha, frame_tick, offset, e_col, e_row, e_ft, e_off);
            end
            seen[offset] = 1'b1;
            if (acender_coluna == 7'b0111111 && saida_linha == 5'b00001) begin
                c6++;
                if (offset == 4'd1) c6_off1++;
            end
        end
        checks++;
        if (seen !== 16'hFFFF) begin
            errors++;
            $display("FAIL left_offsets_seen got %h expected ffff", seen);
        end
        checks++;
        if (c6 == 0 || c6 != c6_off1) begin
            errors++;
            $display("FAIL left_col6_bit7 got %0d lit %0d at offset1 expected equal nonzero", c6, c6_off1);
        end
    endtask

    task automatic test_scroll_right();
        int first = -1;
        int c1 = 0;
        msg_rows = '0;
        msg_rows[15:0] = 16'h0001;
        do_reset(2'b10);
        for (int k = 0; k < 6 * FRAME; k++) begin
            tick();
            checks++;
            if ({acender_coluna, saida_linha, frame_tick, offset} !== {e_col, e_row, e_ft, e_off}) begin
                errors++;
                $display("FAIL right_out k=%0d got %b_%b_%b_%h expected %b_%b_%b_%h", k, acender_coluna, saida_linha, frame_tick, offset, e_col, e_row, e_ft, e_off);
            end
            if (first < 0 && offset != 4'd0) first = int'(offset);
            if (offset == 4'd15 && acender_coluna == 7'b1111101 && saida_linha == 5'b00001) c1++;
        end
        checks++;
        if (first != 15) begin
            errors++;
            $display("FAIL right_first_step got %0d expected 15", first);
        end
        checks++;
        if (c1 == 0) begin
            errors++;
            $display("FAIL right_col1_bit0 got %0d expected nonzero", c1);
        end
    endtask

    task automatic test_blink();
        bit lit [10];
        bit exp_lit [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int f = 0; f < 10; f++) lit[f] = 1'b0;
        msg_rows = '0;
        msg_rows[15:0] = 16'hFFFF;
        do_reset(2'b11);
        for (int k = 1; k <= 10 * FRAME; k++) begin
            if (k == 8 * FRAME + 10) {ch1, ch0} = 2'b00;
            tick();
            checks++;
            if ({acender_coluna, saida_linha, frame_tick, offset} !== {e_col, e_row, e_ft, e_off}) begin
                errors++;
                $display("FAIL blink_out k=%0d got %b_%b_%b_%h expected %b_%b_%b_%h", k, acender_coluna, saida_linha, frame_tick, offset, e_col, e_row, e_ft, e_off);
            end
            if (acender_coluna != 7'h7F) lit[(k - 1) / FRAME] = 1'b1;
        end
        for (int f = 0; f < 10; f++) begin
            checks++;
            if (lit[f] != exp_lit[f]) begin
                errors++;
                $display("FAIL blink_frame%0d got lit=%0d expected lit=%0d", f, lit[f], exp_lit[f]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        logic [6:0] first_col = 7'h7F;
        msg_rows = '0;
        msg_rows[15:0] = 16'h0080;
        do_reset(2'b01);
        while (!(m_off == 5 && ((m_n / SD) % 7) == 3 && (m_n % SD) >= BC) && guard < 2000) begin
            tick();
            guard++;
            checks++;
            if ({acender_coluna, saida_linha, frame_tick, offset} !== {e_col, e_row, e_ft, e_off}) begin
                errors++;
                $display("FAIL midrst_run k=%0d got %b_%b_%b_%h expected %b_%b_%b_%h", guard, acender_coluna, saida_linha, frame_tick, offset, e_col, e_row, e_ft, e_off);
            end
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL midrst_reach got timeout after %0d cycles expected offset 5 col 3", guard);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({acender_coluna, saida_linha, frame_tick, offset} !== {7'h7F, 5'h00, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL midrst_values got %b_%b_%b_%h expected 1111111_00000_0_0", acender_coluna, saida_linha, frame_tick, offset);
        end
        for (int k = 0; k < 3 * SD; k++) begin
            tick();
            if (first_col == 7'h7F && acender_coluna != 7'h7F) first_col = acender_coluna;
        end
        checks++;
        if (first_col !== 7'b1111110) begin
            errors++;
            $display("FAIL midrst_first_drive got %b expected 1111110", first_col);
        end
    endtask

    task automatic test_random();
        do_reset(2'($urandom_range(0, 3)));
        msg_rows = {16'($urandom), 32'($urandom), 32'($urandom)};
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) {ch1, ch0} = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) msg_rows = {16'($urandom), 32'($urandom), 32'($urandom)};
            tick();
            checks++;
            if ({acender_coluna, saida_linha, frame_tick, offset} !== {e_col, e_row, e_ft, e_off}) begin
                errors++;
                $display("FAIL random_out k=%0d got %b_%b_%b_%h expected %b_%b_%b_%h", k, acender_coluna, saida_linha, frame_tick, offset, e_col, e_row, e_ft, e_off);
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_scroll_left();
        test_scroll_right();
        test_blink();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_scan_controller.md
Name: matrix_scan_controller

Overview:
- Sequences column multiplexing of the 5-row x 7-column LED matrix from a 16-bit-wide per-row message.
- Replaces the free-running divider/column-register/7-bit-register chain with one scheduler that owns:
  - column timing and inter-column blanking;
  - the scroll window offset;
  - display mode selection from switches ch1/ch0.
- Sits between the message-pattern storage and the matrix pins.

Parameters:
- SCAN_DIV, 50000: clk cycles per column slot; must be >= 2.
- BLANK_CYC, 64: cycles at the start of each slot with all columns off; must be < SCAN_DIV.
- SCROLL_FRAMES, 120: full 7-column frames per scroll step or blink phase; must be >= 1.

Ports:
- clk, input, 1: system clock (50 MHz).
- rst, input, 1: synchronous active-high reset.
- ch1, input, 1: mode select MSB; asynchronous switch input.
- ch0, input, 1: mode select LSB; asynchronous switch input.
- msg_rows, input, 80: row r message occupies [r*16 +: 16]; r = 0..4.
- acender_coluna, output, 7: column drive, active-low one-hot; bit c low = column c lit.
- saida_linha, output, 5: row data, active-high; bit r = row r.
- frame_tick, output, 1: one-cycle pulse on column wrap 6->0.
- offset, output, 4: current scroll window offset.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values:
  - acender_coluna=7'h7F, saida_linha=0, frame_tick=0, offset=0;
  - column index col=0, prescaler=0, state=BLANK, mode=00, scroll counter=0, blink phase=ON.
- Prescaler:
  - counts 0..SCAN_DIV-1, then wraps to 0;
  - wrap = slot end; col increments, 6 wraps to 0;
  - frame_tick asserted the cycle col becomes 0 after wrapping. It is not asserted out of reset.
- FSM, states BLANK and DRIVE:
  - BLANK while prescaler < BLANK_CYC, else DRIVE; returns to BLANK at every slot start.
  - BLANK: acender_coluna=7'h7F, saida_linha=0.
  - DRIVE: acender_coluna[col]=0, all other bits 1.
  - DRIVE: saida_linha[r] = msg_rows[r*16 + ((offset+col) mod 16)].
- Output latency: outputs reflect state/col/offset one clk after they change.
- ch1/ch0 path:
  - 2-flop synchronizer;
  - synchronized value latched into mode only on frame_tick, so no mid-frame tearing.
- Modes:
  - 00 static: offset frozen.
  - 01 scroll left: offset+1 every SCROLL_FRAMES frames; 15 wraps to 0.
  - 10 scroll right: offset-1 every SCROLL_FRAMES frames; 0 wraps to 15.
  - 11 blink: offset frozen; display alternates SCROLL_FRAMES frames ON, SCROLL_FRAMES frames OFF. During OFF, DRIVE outputs equal BLANK outputs.
- Scroll/blink frame counter: increments on frame_tick; at SCROLL_FRAMES-1 it wraps and performs the step or phase toggle.
- Simultaneous step and mode change on the same frame_tick:
  - the step uses the old mode;
  - the new mode is then latched, the counter is cleared, and blink phase is forced ON.
- msg_rows is sampled combinationally each DRIVE cycle. Changes take effect on the next registered output.
- Reset mid-operation (any state/col): next cycle all reset values; display dark for a full BLANK_CYC.

Optional Feature:
- Macro SCAN_DIM_EN.
- Defined:
  - adds input port dim (1 bit);
  - when dim=1, DRIVE ends at prescaler = BLANK_CYC + (SCAN_DIV-BLANK_CYC)/2; the remainder of the slot is BLANK, giving about half brightness;
  - dim is sampled at slot start.
- Undefined: no dim port; DRIVE lasts to slot end.

Decomposition:
- Package matrix_pkg holds:
  - N_ROWS=5, N_COLS=7, MSG_W=16, COL_OFF=7'h7F;
  - mode enum: MODE_STATIC, MODE_LEFT, MODE_RIGHT, MODE_BLINK;
  - state enum: ST_BLANK, ST_DRIVE.
- One sub-module, matrix_tick_gen: prescaler plus column counter, emitting slot_start, col, frame_tick.
- FSM, mode and offset logic stay in the top.

Test Plan (SCAN_DIV=4, BLANK_CYC=1, SCROLL_FRAMES=2):
1. rst=1 for 3 cycles, then 0 → during reset and on first cycle after: acender_coluna=7'h7F, saida_linha=0, offset=0, frame_tick=0.
2. Mode 00; row0=16'h0001, others 0 → column 0 DRIVE: acender_coluna=7'b1111110, saida_linha=5'b00001. Columns 1-6: saida_linha=0. Each slot starts with 1 cycle of 7'h7F.
3. Mode 01, same message → offset=1 after 2 frame_ticks; column 6 shows bit 7. After 32 frames offset returns to 0.
4. Mode 10 from offset 0 → offset=15 after 2 frames; column 1 then shows bit 0.
5. Mode 11, row0=16'hFFFF → 2 frames with lit columns, 2 frames constant 7'h7F, repeating. Switching ch to 00 mid-frame takes effect only at the next frame_tick.
6. rst pulsed during column 3 DRIVE with offset=5 → next cycle acender_coluna=7'h7F, offset=0; next DRIVE is column 0.
